boton_debounce: RTL
===================

Name: boton_debounce

Overview:
- Upstream conditioning stage for the push-button counter.
- Takes the raw, asynchronous, bouncing push-button level and synchronises it to clk.
- Debounces it with a configurable stability window.
- Emits exactly one single-cycle pulse per confirmed press on boton_o, which drives the counter's boton_i input directly. It also exports the debounced level.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles the synchronised input must hold a new level before it is accepted (5 ms at 100 MHz). Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the internal stability counter. Derived; not overridden.

Ports:
- clk  input  1  system clock, all state on its rising edge.
- reset_i  input  1  asynchronous active-high reset.
- boton_raw_i  input  1  raw push-button level, asynchronous to clk, 1 = pressed.
- boton_o  output  1  one-cycle pulse per debounced press; connects to the counter's boton_i.
- nivel_o  output  1  debounced button level, registered.

Behaviour:
- Reset (asynchronous, active-high) clears all flops:
  - sync_ff1 = 0, sync_ff2 = 0.
  - state = IDLE, cnt = 0.
  - boton_o = 0, nivel_o = 0.
  - Release of reset takes effect on the next clk edge.
- Synchroniser: two-flop chain, boton_raw_i -> sync_ff1 -> sync_ff2. The FSM only ever looks at sync_ff2.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Registered, one transition per clk edge.
- IDLE:
  - sync_ff2 = 1 -> PRESS_WAIT, cnt <= 0.
  - Otherwise stay.
- PRESS_WAIT:
  - sync_ff2 = 0 -> IDLE, cnt <= 0 (bounce rejected, no pulse).
  - sync_ff2 = 1 and cnt = DEBOUNCE_CYCLES-1 -> PRESSED, boton_o <= 1, nivel_o <= 1.
  - Otherwise cnt <= cnt+1.
- PRESSED:
  - sync_ff2 = 0 -> RELEASE_WAIT, cnt <= 0.
  - Otherwise stay. A held button produces no further pulses.
- RELEASE_WAIT:
  - sync_ff2 = 1 -> PRESSED, cnt <= 0. No new pulse; nivel_o stays 1.
  - sync_ff2 = 0 and cnt = DEBOUNCE_CYCLES-1 -> IDLE, nivel_o <= 0.
  - Otherwise cnt <= cnt+1.
- boton_o:
  - Registered; high for exactly one clk cycle, in the cycle after the PRESS_WAIT->PRESSED transition edge.
  - Cleared on every other edge.
  - Never high on two consecutive cycles.
- nivel_o: 1 exactly while state is PRESSED or RELEASE_WAIT (registered alongside the state).
- Press latency: edge 1 is the first rising edge that samples boton_raw_i = 1. If the input then holds stable, boton_o is high in the cycle following edge DEBOUNCE_CYCLES+3. Release latency to nivel_o = 0 is identical.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Any level change during a wait state restarts the window from zero.
- Reset mid-operation: all state returns to reset values immediately. boton_o and nivel_o drop asynchronously. A button still held when reset deasserts is treated as a new press and yields one pulse after DEBOUNCE_CYCLES+3 edges.

Test Plan (DEBOUNCE_CYCLES = 4):
- Clean press: reset, then boton_raw_i = 1 held for 20 cycles -> boton_o = 1 in exactly one cycle, after edge 7. nivel_o = 1 from the same cycle. A downstream counter reads 1.
- Bounce rejection: boton_raw_i toggles 1,0,1,0 every 2 cycles for 16 cycles, then 0 -> boton_o never asserts, nivel_o stays 0.
- Bouncy press then stable: 3 short bounces, then held 1 for 10 cycles -> exactly one boton_o pulse, 7 edges after the final rising transition is sampled.
- Release glitch: press confirmed, then boton_raw_i = 0 for 2 cycles, then 1 again -> no second pulse, nivel_o stays 1. Then a full release: nivel_o = 0 7 edges after the 0 is first sampled.
- Repeated presses: five clean press/release pairs (held 12 cycles, released 12 cycles) -> exactly five single-cycle boton_o pulses.
- Async reset: assert reset_i mid-PRESS_WAIT and mid-PRESSED, between clk edges, with the button held -> boton_o and nivel_o are 0 immediately. After deassert, one pulse follows 7 edges later.

Source files
------------

// File: rtl/boton_debounce.sv
// Push-button conditioner: synchronises the raw button level to clk,
// debounces it over DEBOUNCE_CYCLES and emits one pulse per confirmed press.
//   clk          system clock, rising edge
//   reset_i      asynchronous active-high reset
//   boton_raw_i  raw, asynchronous, bouncing button level (1 = pressed)
//   boton_o      single-cycle pulse per debounced press
//   nivel_o      debounced button level
module boton_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_i,
  input  logic boton_raw_i,
  output logic boton_o,
  output logic nivel_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_ff1;
  logic             sync_ff2;

  // Two-flop synchroniser plus debounce FSM; only sync_ff2 feeds the FSM.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      boton_o  <= 1'b0;
      nivel_o  <= 1'b0;
    end else begin
      sync_ff1 <= boton_raw_i;
      sync_ff2 <= sync_ff1;
      boton_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_ff2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync_ff2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            boton_o <= 1'b1;
            nivel_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!sync_ff2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end

        RELEASE_WAIT: begin
          // A return to 1 cancels the release without a new pulse.
          if (sync_ff2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            nivel_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          nivel_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
